// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU controller: operation codes, FSM states and iteration sizing.
// Optional feature macro used by mdu_ctrl: MDU_FAST_MULT_EN.
package mdu_pkg;

    localparam int ITER_CNT = 32;
    localparam int CNT_W    = $clog2(ITER_CNT);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mdu_state_e;

    // Two's-complement magnitude; -2^31 maps to 32'h8000_0000, which is its correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signed_op);
        return (signed_op && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 unsigned datapath shared by multiply (shift-add) and divide (restoring subtract).
// res_hi/res_lo present the value after the current step so the final step can be written directly.
module mdu_iter_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    // acc: product high half / 33-bit partial remainder; lo: multiplier / dividend-quotient shifter.
    logic [32:0] acc_q, acc_d;
    logic [31:0] lo_q, lo_d, opb_q;
    logic [32:0] add, shifted, diff;

    always_comb begin
        acc_d   = acc_q;
        lo_d    = lo_q;
        add     = lo_q[0] ? (acc_q + {1'b0, opb_q}) : acc_q;
        shifted = {acc_q[31:0], lo_q[31]};
        diff    = shifted - {1'b0, opb_q};
        if (is_div) begin
            if (!diff[32]) begin
                acc_d = diff;
                lo_d  = {lo_q[30:0], 1'b1};
            end else begin
                acc_d = shifted;
                lo_d  = {lo_q[30:0], 1'b0};
            end
        end else begin
            acc_d = {1'b0, add[32:1]};
            lo_d  = {add[0], lo_q[31:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            lo_q  <= '0;
            opb_q <= '0;
        end else if (load) begin
            acc_q <= '0;
            lo_q  <= a_mag;
            opb_q <= b_mag;
        end else if (step) begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
        end
    end

    assign res_hi = acc_d[31:0];
    assign res_lo = lo_d;

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/BUSY/DONE sequencing, operand sign handling and the HI/LO registers.
// Define MDU_FAST_MULT_EN to complete MULT/MULTU in a single cycle without entering BUSY.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        mult_div_run,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q, neg_q, neg_r;
    logic             is_mult_op, is_div_op, is_signed, iter_op, issue, mt_wr;
    logic             run, load, step, finish, fast_wr;
    logic [31:0]      a_mag, b_mag, core_hi, core_lo;
    logic [63:0]      prod_raw, fixed_res, fast_res;

    assign is_mult_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op  = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign issue      = op_valid && !flush && (state_q == ST_IDLE);
    assign mt_wr      = issue && ((op == OP_MTHI) || (op == OP_MTLO));
    assign a_mag      = magnitude(src_a, is_signed);
    assign b_mag      = magnitude(src_b, is_signed);

`ifdef MDU_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign iter_op   = is_div_op;
    assign fast_wr   = issue && is_mult_op;
    assign fast_prod = {32'b0, a_mag} * {32'b0, b_mag};
    assign fast_res  = (is_signed && (src_a[31] ^ src_b[31])) ? -fast_prod : fast_prod;
`else
    assign iter_op   = is_mult_op || is_div_op;
    assign fast_wr   = 1'b0;
    assign fast_res  = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue && iter_op) begin
                    run     = 1'b1;
                    load    = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    run  = 1'b1;
                    step = 1'b1;
                    if (cnt_q == '0) begin
                        finish  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mult_div_run = resetn && run;

    mdu_iter_core u_core (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .is_div (div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    // Unsigned core result with recorded signs restored.
    assign prod_raw = {core_hi, core_lo};
    always_comb begin
        fixed_res = neg_q ? -prod_raw : prod_raw;
        if (div_q) begin
            fixed_res[31:0]  = neg_q ? -core_lo : core_lo;
            fixed_res[63:32] = neg_r ? -core_hi : core_hi;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= finish || fast_wr;
            if (load) begin
                cnt_q <= CNT_W'(ITER_CNT - 1);
                div_q <= is_div_op;
                neg_q <= is_signed && (src_a[31] ^ src_b[31]);
                neg_r <= is_signed && src_a[31];
            end else if (step) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (finish) begin
                {hi, lo} <= fixed_res;
            end else if (fast_wr) begin
                {hi, lo} <= fast_res;
            end else if (mt_wr) begin
                if (op == OP_MTHI) hi <= src_a;
                else               lo <= src_a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected {hi,lo}; a monitor pops on each done pulse.
// Random operations are checked against a plain-arithmetic reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        mult_div_run;
    logic [31:0] hi, lo;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    mdu_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .op_valid     (op_valid),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .mult_div_run (mult_div_run),
        .hi           (hi),
        .lo           (lo),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: signed results from truncating integer division and full-width products.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        res = '0;
        case (o)
            3'd0: res = 64'(sa * sb);
            3'd1: res = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) begin
                    res = {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check(name_q.pop_front(), {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Issue one iterative op, hold it in EX while stalled, and measure the stall length.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        int n;
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        exp_q.push_back(exp);
        name_q.push_back(name);
        #1;
        n = 0;
        while (mult_div_run && n < 100) begin
            n++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        check({name, "_run_len"}, 64'(n), 64'd33);
        check({name, "_done_pulse"}, 64'(done), 64'd1);
    endtask

    initial begin
        logic [63:0] hold;
        logic [2:0]  o;
        logic [31:0] a, b;

        resetn   = 1'b0;
        op_valid = 1'b0;
        op       = '0;
        src_a    = '0;
        src_b    = '0;
        flush    = 1'b0;
        #12;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_run", 64'(mult_div_run), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");
        run_op(3'd2, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        run_op(3'd0, -32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mult_m3_5");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max_b2b");
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_min_min");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "div_min_m1");
        run_op(3'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "divu_5_0");
        run_op(3'd2, -32'sd7, 32'd0, {32'hFFFF_FFF9, 32'h1}, "div_m7_0");

        // MTLO / MTHI: written at the accept edge with no stall.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd5; src_a = 32'h1234;
        #1 check("mtlo_run", 64'(mult_div_run), 64'd0);
        @(negedge clk);
        check("mtlo_lo", 64'(lo), 64'h1234);
        op = 3'd4; src_a = 32'hCAFE_0001;
        #1 check("mthi_run", 64'(mult_div_run), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        check("mthi_hilo", {hi, lo}, {32'hCAFE_0001, 32'h1234});
        run_op(3'd1, 32'd6, 32'd7, 64'd42, "multu_after_mt");

        // Undefined op code behaves as a no-op.
        hold = {hi, lo};
        @(negedge clk);
        op_valid = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF;
        #1 check("noop_run", 64'(mult_div_run), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        check("noop_hilo", {hi, lo}, hold);

        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(o, a, b, model(o, a, b), $sformatf("rand%0d_op%0d", i, o));
        end

        // Flush at BUSY cycle 10: no stall that cycle, no result, HI/LO untouched.
        hold = {hi, lo};
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1; op_valid = 1'b0;
        #1 check("flush_run", 64'(mult_div_run), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_hold", {hi, lo}, hold);
        repeat (40) @(negedge clk);
        check("flush_hold_late", {hi, lo}, hold);
        run_op(3'd3, 32'd1000, 32'd3, {32'd1, 32'd333}, "divu_after_flush");

        // Reset mid-BUSY abandons the operation.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; src_a = 32'd9; src_b = 32'd9;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_busy_run", 64'(mult_div_run), 64'd0);
        check("rst_busy_hilo", {hi, lo}, 64'd0);
        check("rst_busy_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        op_valid = 1'b0;
        resetn   = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_no_pending", {hi, lo}, 64'd0);
        run_op(3'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, "divu_after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 op_valid  input  1  EX-stage instruction is an MDU operation.
REQ-004 op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; others are no-ops.
REQ-005 src_a  input  32  rs value (multiplicand / dividend / MTxx data).
REQ-006 src_b  input  32  rt value (multiplier / divisor).
REQ-007 flush  input  1  EX flush on exception; cancels any operation.
REQ-008 mult_div_run  output  1  stall request to the hazard control unit.
REQ-009 hi  output  32  registered HI.
REQ-010 lo  output  32  registered LO.
REQ-011 done  output  1  one-cycle pulse: HI/LO written by MULT/DIV this cycle.

Function
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 IDLE: when op_valid & ~flush & op in 0..3, SHALL latch operands and go to BUSY with iteration counter = 31.
REQ-014 Signed ops SHALL latch operand magnitudes and record the result signs: quotient negative iff operand signs differ; remainder takes the dividend's sign; product negative iff operand signs differ.
REQ-015 BUSY: one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide); the counter decrements each cycle.
REQ-016 At counter==0 the SHALL write HI/LO with sign correction applied: MULT gives {hi,lo}=product; DIV gives lo=quotient, hi=remainder. It SHALL then go to DONE with done=1 for that cycle.
REQ-017 DONE SHALL last one cycle, ignore op_valid (the same instruction is still in EX), and return to IDLE.
REQ-018 mult_div_run = (IDLE & op_valid & ~flush & op in 0..3) | (BUSY & ~flush); it is combinational and is 1 for exactly 33 consecutive cycles per accepted op.
REQ-019 MTHI/MTLO in IDLE with ~flush SHALL write hi/lo = src_a at that edge, keep run=0 and stay in IDLE.
REQ-020 flush in any state SHALL force IDLE at the next edge, leave HI/LO unchanged, and give done=0.
REQ-021 Divide by zero SHALL NOT trap: the unsigned core gives lo=32'hFFFFFFFF and hi=|dividend|; sign correction then applies per REQ-014; latency is unchanged.
REQ-022 MULT -2^31 x -2^31 SHALL yield 64'h4000_0000_0000_0000; DIV -2^31 / -1 SHALL yield lo=32'h8000_0000, hi=0.
REQ-023 Result widths: product is 64 bits; the divide core uses a 33-bit partial remainder.

Reset
REQ-024 While resetn=0: state=IDLE, counter=0, hi=0, lo=0, done=0, mult_div_run=0, operand registers=0.
REQ-025 Reset asserted mid-BUSY SHALL abandon the operation immediately; there is no pending result after release.

Configuration
REQ-026 Macro MDU_FAST_MULT_EN: when defined, MULT/MULTU SHALL complete in IDLE at the accept edge with a single-cycle 64-bit multiply, run=0, no BUSY/DONE, and done=1 next cycle; divides are unchanged.
REQ-027 Without MDU_FAST_MULT_EN, multiplies SHALL use the 32-cycle iterative path.

Structure
REQ-028 Package mdu_pkg SHALL hold the op encodings, the FSM state type, ITER_CNT=32 and the counter width.
REQ-029 One sub-module, mdu_iter_core, SHALL hold the shift/add/subtract datapath; mdu_ctrl holds the FSM, sign handling and HI/LO.

Verification
REQ-030 DIVU 100/7 at cycle T: run=1 for T..T+32, done at T+33, lo=14, hi=2.
REQ-031 DIV -7/2: lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. MULT -3x5: {hi,lo}=64'hFFFF_FFFF_FFFF_FFF1.
REQ-032 flush asserted at BUSY cycle 10: run=0 that cycle, IDLE next edge, HI/LO hold prior values, no done.
REQ-033 MTLO 32'h1234 while IDLE: lo=32'h1234 the next cycle, run never asserted. A back-to-back MULTU immediately after DONE is accepted.
REQ-034 DIVU 5/0: lo=32'hFFFFFFFF, hi=5. resetn pulsed low mid-BUSY: all outputs 0 and state IDLE.
